median9_sorter_sched: RTL

- Sequencer that computes the exact median of a 3x3 pixel window using one shared combinational 3-input ascending sorter.
- The sorter is time-multiplexed over 7 cycles using the row-sort / column-select / final-select method.
- Sits between the window buffer (line-buffer stage) and the filtered-pixel output stage of the median filter.
- Trades throughput (one window per 9 cycles) for a single sorter instance instead of seven.

---
 rtl/median_pkg.sv | 8 +
 rtl/Ascending_Sorter_3inputs_8bits.sv | 18 +
 rtl/median9_sorter_sched.sv | 126 ++++++++++++
 3 files changed

// File: rtl/median_pkg.sv
// median_pkg: shared widths and scheduler state encoding for the 3x3 median filter
package median_pkg;
    localparam int PIX_W = 8;
    localparam int WIN_N = 9;
    typedef enum logic [3:0] {
        IDLE, ROW0, ROW1, ROW2, COLLO, COLMD, COLHI, FINAL, DONE
    } sched_state_t;
endpackage

// File: rtl/Ascending_Sorter_3inputs_8bits.sv
// Ascending_Sorter_3inputs_8bits: combinational min/mid/max of three 8-bit values
module Ascending_Sorter_3inputs_8bits (
    input  logic [7:0] in_a,
    input  logic [7:0] in_b,
    input  logic [7:0] in_c,
    output logic [7:0] out_min,
    output logic [7:0] out_mid,
    output logic [7:0] out_max
);
    logic [7:0] lo_ab, hi_ab;
    always_comb begin
        lo_ab   = in_a < in_b ? in_a : in_b;
        hi_ab   = in_a < in_b ? in_b : in_a;
        out_min = in_c < lo_ab ? in_c : lo_ab;
        out_max = in_c > hi_ab ? in_c : hi_ab;
        out_mid = in_c < lo_ab ? lo_ab : (in_c > hi_ab ? hi_ab : in_c);
    end
endmodule

// File: rtl/median9_sorter_sched.sv
// median9_sorter_sched: exact 3x3 median via one shared 3-input sorter over seven steps
module median9_sorter_sched
    import median_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [9*DATA_W-1:0]   in_window,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_median,
    output logic                  busy
);
    if (DATA_W != PIX_W) begin : g_bad_width
        $error("median9_sorter_sched: DATA_W must be 8");
    end

    sched_state_t      state_q, state_d;
    logic [DATA_W-1:0] win_q [WIN_N];
    logic [DATA_W-1:0] win_d [WIN_N];
    logic [DATA_W-1:0] lo_q [3], lo_d [3], md_q [3], md_d [3], hi_q [3], hi_d [3];
    logic [DATA_W-1:0] c_lo_q, c_lo_d, c_md_q, c_md_d, c_hi_q, c_hi_d, med_q, med_d;
    logic [DATA_W-1:0] s_a, s_b, s_c, s_min, s_mid, s_max;

    Ascending_Sorter_3inputs_8bits u_sorter (
        .in_a(s_a), .in_b(s_b), .in_c(s_c),
        .out_min(s_min), .out_mid(s_mid), .out_max(s_max)
    );

    // Sorter operands follow the step: rows, then column groups, then the final triple
    always_comb begin
        s_a = '0;
        s_b = '0;
        s_c = '0;
        case (state_q)
            ROW0:    {s_a, s_b, s_c} = {win_q[0], win_q[1], win_q[2]};
            ROW1:    {s_a, s_b, s_c} = {win_q[3], win_q[4], win_q[5]};
            ROW2:    {s_a, s_b, s_c} = {win_q[6], win_q[7], win_q[8]};
            COLLO:   {s_a, s_b, s_c} = {lo_q[0], lo_q[1], lo_q[2]};
            COLMD:   {s_a, s_b, s_c} = {md_q[0], md_q[1], md_q[2]};
            COLHI:   {s_a, s_b, s_c} = {hi_q[0], hi_q[1], hi_q[2]};
            FINAL:   {s_a, s_b, s_c} = {c_lo_q, c_md_q, c_hi_q};
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        lo_d    = lo_q;
        md_d    = md_q;
        hi_d    = hi_q;
        c_lo_d  = c_lo_q;
        c_md_d  = c_md_q;
        c_hi_d  = c_hi_q;
        med_d   = med_q;
        case (state_q)
            IDLE: if (in_valid) begin
                for (int i = 0; i < WIN_N; i++) win_d[i] = in_window[DATA_W*i +: DATA_W];
                state_d = ROW0;
            end
            ROW0: begin
                {lo_d[0], md_d[0], hi_d[0]} = {s_min, s_mid, s_max};
                state_d = ROW1;
            end
            ROW1: begin
                {lo_d[1], md_d[1], hi_d[1]} = {s_min, s_mid, s_max};
                state_d = ROW2;
            end
            ROW2: begin
                {lo_d[2], md_d[2], hi_d[2]} = {s_min, s_mid, s_max};
                state_d = COLLO;
            end
            COLLO: begin
                c_lo_d  = s_max;
                state_d = COLMD;
            end
            COLMD: begin
                c_md_d  = s_mid;
                state_d = COLHI;
            end
            COLHI: begin
                c_hi_d  = s_min;
                state_d = FINAL;
            end
            FINAL: begin
                med_d   = s_mid;
                state_d = DONE;
            end
            DONE:    state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            win_q   <= '{default: '0};
            lo_q    <= '{default: '0};
            md_q    <= '{default: '0};
            hi_q    <= '{default: '0};
            c_lo_q  <= '0;
            c_md_q  <= '0;
            c_hi_q  <= '0;
            med_q   <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            lo_q    <= lo_d;
            md_q    <= md_d;
            hi_q    <= hi_d;
            c_lo_q  <= c_lo_d;
            c_md_q  <= c_md_d;
            c_hi_q  <= c_hi_d;
            med_q   <= med_d;
        end
    end

    assign in_ready   = state_q == IDLE;
    assign out_valid  = state_q == DONE;
    assign busy       = state_q != IDLE;
    assign out_median = med_q;
endmodule
